// File: rtl/alu_seq_hs.sv
// alu_seq_hs: handshaked signed ALU with a 16-op opcode map.
// Every accepted op goes through one operand-capture stage. Results come out one cycle later.
// Division is the exception: it runs an iterative restoring divider.
// The divider and its BUSY state exist only when the macro ALU_DIV_EN is defined.
// Without ALU_DIV_EN, opcode 0011 completes at once as a divide error.
module alu_seq_hs #(
  parameter int DATA_WIDTH      = 16,
  parameter int ARITH_OUT_WIDTH = 2*DATA_WIDTH,
  parameter int LOGIC_OUT_WIDTH = DATA_WIDTH,
  parameter int CMP_OUT_WIDTH   = 2,
  parameter int SHIFT_OUT_WIDTH = DATA_WIDTH+1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_WIDTH-1:0]      A,
  input  logic [DATA_WIDTH-1:0]      B,
  input  logic [3:0]                 ALU_FUNC,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic                       OUT_VALID,
  output logic [ARITH_OUT_WIDTH-1:0] Arith_OUT,
  output logic [LOGIC_OUT_WIDTH-1:0] Logic_OUT,
  output logic [CMP_OUT_WIDTH-1:0]   CMP_OUT,
  output logic [SHIFT_OUT_WIDTH-1:0] SHIFT_OUT,
  output logic                       Arith_Flag,
  output logic                       Logic_Flag,
  output logic                       CMP_Flag,
  output logic                       SHIFT_Flag,
  output logic                       DIV_ERR
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ARITH_OUT_WIDTH;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_reg, state_next;

  // Captured operands of the op being completed in the next cycle
  logic          pend_reg, pend_next;
  logic [DW-1:0] op_a_reg, op_a_next, op_b_reg, op_b_next;
  logic [3:0]    op_func_reg, op_func_next;

  // Result registers
  logic [AW-1:0]              arith_reg, arith_next;
  logic [LOGIC_OUT_WIDTH-1:0] logic_reg, logic_next;
  logic [CMP_OUT_WIDTH-1:0]   cmp_reg, cmp_next;
  logic [SHIFT_OUT_WIDTH-1:0] shift_reg, shift_next;
  logic arith_flag_reg, arith_flag_next, logic_flag_reg, logic_flag_next;
  logic cmp_flag_reg, cmp_flag_next, shift_flag_reg, shift_flag_next;
  logic div_err_reg, div_err_next, out_valid_reg, out_valid_next;

  // Single-cycle datapath. It is fed from the captured operands.
  // Add, sub and mul work at the full arithmetic width, so no result wraps.
  logic [AW-1:0]   a_ext, b_ext, sum_w, dif_w, prod_w;
  logic [DW:0]     sra_a, shl_a, sra_b, shl_b;
  logic            a_eq_b, a_gt_b, a_lt_b;

  assign a_ext  = {{(AW-DW){op_a_reg[DW-1]}}, op_a_reg};
  assign b_ext  = {{(AW-DW){op_b_reg[DW-1]}}, op_b_reg};
  assign sum_w  = a_ext + b_ext;
  assign dif_w  = a_ext - b_ext;
  assign prod_w = a_ext * b_ext;
  assign sra_a  = {op_a_reg[DW-1], op_a_reg[DW-1], op_a_reg[DW-1:1]};
  assign shl_a  = {op_a_reg, 1'b0};
  assign sra_b  = {op_b_reg[DW-1], op_b_reg[DW-1], op_b_reg[DW-1:1]};
  assign shl_b  = {op_b_reg, 1'b0};
  assign a_eq_b = (op_a_reg == op_b_reg);
  assign a_gt_b = ($signed(op_a_reg) > $signed(op_b_reg));
  assign a_lt_b = ($signed(op_a_reg) < $signed(op_b_reg));

`ifdef ALU_DIV_EN
  localparam int CW = $clog2(DATA_WIDTH+1);

  // Restoring divider state.
  // quo_reg first holds |A|. It then collects the quotient bits, MSB first.
  logic [DW-1:0] rem_reg, rem_next, quo_reg, quo_next, dvsr_reg, dvsr_next;
  logic          neg_reg, neg_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] a_mag, b_mag;
  logic [DW:0]   rem_shift, trial;
  logic [AW-1:0] q_ext, div_q;

  assign a_mag     = A[DW-1] ? -A : A;
  assign b_mag     = B[DW-1] ? -B : B;
  assign rem_shift = {rem_reg, quo_reg[DW-1]};
  assign trial     = rem_shift - {1'b0, dvsr_reg};
  // The quotient magnitude is at most 2^(DW-1). Negating it at full width gives the no-wrap result.
  assign q_ext     = {{(AW-DW){1'b0}}, quo_reg};
  assign div_q     = neg_reg ? -q_ext : q_ext;
`endif

  // Next-state logic: complete the captured op, accept new ops, step the divider
  always_comb begin
    state_next      = state_reg;
    pend_next       = 1'b0;
    op_a_next       = op_a_reg;
    op_b_next       = op_b_reg;
    op_func_next    = op_func_reg;
    arith_next      = arith_reg;
    logic_next      = logic_reg;
    cmp_next        = cmp_reg;
    shift_next      = shift_reg;
    arith_flag_next = arith_flag_reg;
    logic_flag_next = logic_flag_reg;
    cmp_flag_next   = cmp_flag_reg;
    shift_flag_next = shift_flag_reg;
    div_err_next    = div_err_reg;
    out_valid_next  = 1'b0;
`ifdef ALU_DIV_EN
    rem_next  = rem_reg;
    quo_next  = quo_reg;
    dvsr_next = dvsr_reg;
    neg_next  = neg_reg;
    cnt_next  = cnt_reg;
`endif

    if (pend_reg) begin
      out_valid_next  = 1'b1;
      arith_flag_next = 1'b0;
      logic_flag_next = 1'b0;
      cmp_flag_next   = 1'b0;
      shift_flag_next = 1'b0;
      div_err_next    = 1'b0;
      case (op_func_reg[3:2])
        2'b00: begin
          arith_flag_next = 1'b1;
          case (op_func_reg[1:0])
            2'b00:   arith_next = sum_w;
            2'b01:   arith_next = dif_w;
            2'b10:   arith_next = prod_w;
            // A divide only reaches this path when it is a divide error (B==0, or no divider)
            default: begin
              arith_next   = '0;
              div_err_next = 1'b1;
            end
          endcase
        end
        2'b01: begin
          logic_flag_next = 1'b1;
          case (op_func_reg[1:0])
            2'b00:   logic_next = LOGIC_OUT_WIDTH'(op_a_reg & op_b_reg);
            2'b01:   logic_next = LOGIC_OUT_WIDTH'(op_a_reg | op_b_reg);
            2'b10:   logic_next = LOGIC_OUT_WIDTH'(~(op_a_reg & op_b_reg));
            default: logic_next = LOGIC_OUT_WIDTH'(~(op_a_reg | op_b_reg));
          endcase
        end
        2'b10: begin
          cmp_flag_next = 1'b1;
          case (op_func_reg[1:0])
            2'b00:   cmp_next = '0;
            2'b01:   cmp_next = a_eq_b ? CMP_OUT_WIDTH'(2'b01) : '0;
            2'b10:   cmp_next = a_gt_b ? CMP_OUT_WIDTH'(2'b10) : '0;
            default: cmp_next = a_lt_b ? CMP_OUT_WIDTH'(2'b11) : '0;
          endcase
        end
        default: begin
          shift_flag_next = 1'b1;
          case (op_func_reg[1:0])
            2'b00:   shift_next = SHIFT_OUT_WIDTH'(sra_a);
            2'b01:   shift_next = SHIFT_OUT_WIDTH'(shl_a);
            2'b10:   shift_next = SHIFT_OUT_WIDTH'(sra_b);
            default: shift_next = SHIFT_OUT_WIDTH'(shl_b);
          endcase
        end
      endcase
    end

    case (state_reg)
      IDLE: begin
        if (IN_VALID) begin
`ifdef ALU_DIV_EN
          if (ALU_FUNC == 4'b0011 && B != '0) begin
            state_next = BUSY;
            rem_next   = '0;
            quo_next   = a_mag;
            dvsr_next  = b_mag;
            neg_next   = A[DW-1] ^ B[DW-1];
            cnt_next   = '0;
          end else
`endif
          begin
            pend_next    = 1'b1;
            op_a_next    = A;
            op_b_next    = B;
            op_func_next = ALU_FUNC;
          end
        end
      end
      BUSY: begin
`ifdef ALU_DIV_EN
        if (cnt_reg == CW'(DW)) begin
          state_next      = IDLE;
          out_valid_next  = 1'b1;
          arith_next      = div_q;
          arith_flag_next = 1'b1;
          logic_flag_next = 1'b0;
          cmp_flag_next   = 1'b0;
          shift_flag_next = 1'b0;
          div_err_next    = 1'b0;
        end else begin
          rem_next = trial[DW] ? rem_shift[DW-1:0] : trial[DW-1:0];
          quo_next = {quo_reg[DW-2:0], ~trial[DW]};
          cnt_next = cnt_reg + CW'(1);
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State and result registers. Reset aborts any division in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      pend_reg       <= 1'b0;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_func_reg    <= '0;
      arith_reg      <= '0;
      logic_reg      <= '0;
      cmp_reg        <= '0;
      shift_reg      <= '0;
      arith_flag_reg <= 1'b0;
      logic_flag_reg <= 1'b0;
      cmp_flag_reg   <= 1'b0;
      shift_flag_reg <= 1'b0;
      div_err_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
`ifdef ALU_DIV_EN
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvsr_reg <= '0;
      neg_reg  <= 1'b0;
      cnt_reg  <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      pend_reg       <= pend_next;
      op_a_reg       <= op_a_next;
      op_b_reg       <= op_b_next;
      op_func_reg    <= op_func_next;
      arith_reg      <= arith_next;
      logic_reg      <= logic_next;
      cmp_reg        <= cmp_next;
      shift_reg      <= shift_next;
      arith_flag_reg <= arith_flag_next;
      logic_flag_reg <= logic_flag_next;
      cmp_flag_reg   <= cmp_flag_next;
      shift_flag_reg <= shift_flag_next;
      div_err_reg    <= div_err_next;
      out_valid_reg  <= out_valid_next;
`ifdef ALU_DIV_EN
      rem_reg  <= rem_next;
      quo_reg  <= quo_next;
      dvsr_reg <= dvsr_next;
      neg_reg  <= neg_next;
      cnt_reg  <= cnt_next;
`endif
    end
  end

  assign IN_READY   = (state_reg == IDLE);
  assign OUT_VALID  = out_valid_reg;
  assign Arith_OUT  = arith_reg;
  assign Logic_OUT  = logic_reg;
  assign CMP_OUT    = cmp_reg;
  assign SHIFT_OUT  = shift_reg;
  assign Arith_Flag = arith_flag_reg;
  assign Logic_Flag = logic_flag_reg;
  assign CMP_Flag   = cmp_flag_reg;
  assign SHIFT_Flag = shift_flag_reg;
  assign DIV_ERR    = div_err_reg;

endmodule
